// File: rtl/uart_mmio_pkg.sv
// ============================================================================
// Module : uart_mmio_pkg
// Brief  : Register offsets, STATUS bit positions and field widths shared by
//          the UART MMIO bridge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_mmio_pkg;

    localparam logic [3:0] RXDATA_OFF = 4'h0;
    localparam logic [3:0] TXDATA_OFF = 4'h4;
    localparam logic [3:0] STATUS_OFF = 4'h8;
    localparam logic [3:0] CLEAR_OFF  = 4'hC;

    localparam int c_ST_RX_NONEMPTY = 0;
    localparam int c_ST_TX_NOTFULL  = 1;
    localparam int c_ST_RX_OVERRUN  = 2;
    localparam int c_ST_TX_OVERRUN  = 3;
    localparam int c_ST_RX_UNDERRUN = 4;

    localparam int c_ST_CNT_W       = 8;
    localparam int c_ST_RX_CNT_LSB  = 8;
    localparam int c_ST_TX_CNT_LSB  = 16;

    function automatic logic [c_ST_CNT_W-1:0] sat_count(input logic [31:0] v);
        return (v > 32'((1 << c_ST_CNT_W) - 1)) ? '1 : v[c_ST_CNT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_mmio_bridge_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with wrap-bit pointers; a pop frees the slot for
//          a push in the same cycle, so push+pop works at any fill level.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign count = r_wptr - r_rptr;
    assign dout  = r_mem[r_rptr[c_AW-1:0]];

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_mmio_bridge.sv
// ============================================================================
// Module : uart_mmio_bridge
// Brief  : CPU load/store to ready/valid UART bridge with TX/RX FIFOs, STATUS
//          and sticky error flags. Optional macro UART_IRQ_EN adds irq + IE.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter int          CHAR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [31:0]       addr,
    input  logic              re,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              hit,
    output logic [CHAR_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [CHAR_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
`ifdef UART_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int c_TXC_W = $clog2(TX_DEPTH) + 1;
    localparam int c_RXC_W = $clog2(RX_DEPTH) + 1;

    logic               w_access, w_wr, w_rd;
    logic [1:0]         w_word;
    logic               w_sel_rx, w_sel_tx, w_sel_st, w_sel_clr;
    logic               w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [c_TXC_W-1:0] w_tx_count;
    logic               w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [c_RXC_W-1:0] w_rx_count;
    logic [CHAR_W-1:0]  w_rx_head;
    logic               r_run;
    logic [31:0]        r_rdata, w_rd_mux, w_status;
    logic [c_ST_RX_UNDERRUN:c_ST_RX_OVERRUN] r_flags, w_flag_set, w_flag_clr;
    logic               w_unused;

    assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_access = hit & ~stall;
    assign w_wr     = w_access & we;
    assign w_rd     = w_access & re & ~we;
    assign w_word   = addr[3:2];

    assign w_sel_rx  = (w_word == RXDATA_OFF[3:2]);
    assign w_sel_tx  = (w_word == TXDATA_OFF[3:2]);
    assign w_sel_st  = (w_word == STATUS_OFF[3:2]);
    assign w_sel_clr = (w_word == CLEAR_OFF[3:2]);

    // r_run holds the UART-facing outputs quiet until the first edge after reset
    assign tx_valid  = r_run & ~w_tx_empty;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_tx_push = w_wr & w_sel_tx;

    assign rx_ready  = r_run & ~w_rx_full;
    assign w_rx_push = r_run & rx_valid;
    assign w_rx_pop  = w_rd & w_sel_rx;

    sync_fifo #(.WIDTH(CHAR_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (wdata[CHAR_W-1:0]),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    sync_fifo #(.WIDTH(CHAR_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    always_comb begin
        w_flag_set = '0;
        w_flag_set[c_ST_RX_OVERRUN]  = w_rx_push & w_rx_full & ~w_rx_pop;
        w_flag_set[c_ST_TX_OVERRUN]  = w_tx_push & w_tx_full & ~w_tx_pop;
        w_flag_set[c_ST_RX_UNDERRUN] = w_rx_pop & w_rx_empty;
    end

    assign w_flag_clr = (w_wr & w_sel_clr) ?
                        wdata[c_ST_RX_UNDERRUN:c_ST_RX_OVERRUN] : '0;

    always_comb begin
        w_status = '0;
        w_status[c_ST_RX_NONEMPTY] = ~w_rx_empty;
        w_status[c_ST_TX_NOTFULL]  = ~w_tx_full;
        w_status[c_ST_RX_UNDERRUN:c_ST_RX_OVERRUN] = r_flags;
        w_status[c_ST_RX_CNT_LSB +: c_ST_CNT_W] = sat_count(32'(w_rx_count));
        w_status[c_ST_TX_CNT_LSB +: c_ST_CNT_W] = sat_count(32'(w_tx_count));
    end

`ifdef UART_IRQ_EN
    logic [1:0] r_ie;
    logic       r_irq;

    always_comb begin
        w_rd_mux = '0;
        if (w_sel_rx)       w_rd_mux = w_rx_empty ? '0 : 32'(w_rx_head);
        else if (w_sel_st)  w_rd_mux = w_status;
        else if (w_sel_clr) w_rd_mux = {30'b0, r_ie};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ie  <= 2'b00;
            r_irq <= 1'b0;
        end else begin
            if (w_wr & w_sel_clr) r_ie <= wdata[1:0];
            r_irq <= |(r_ie & {w_tx_empty, ~w_rx_empty}) | (|r_flags);
        end
    end

    assign irq = r_irq;
`else
    always_comb begin
        w_rd_mux = '0;
        if (w_sel_rx)      w_rd_mux = w_rx_empty ? '0 : 32'(w_rx_head);
        else if (w_sel_st) w_rd_mux = w_status;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run   <= 1'b0;
            r_rdata <= '0;
            r_flags <= '0;
        end else begin
            r_run   <= 1'b1;
            if (w_rd) r_rdata <= w_rd_mux;
            // a flag raised in the same cycle as its CLEAR stays set
            r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
        end
    end

    assign rdata = r_rdata;

    assign w_unused = &{1'b0, addr[1:0], wdata[31:CHAR_W]};

endmodule

`default_nettype wire
